// File: rtl/mem_port_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter_if
// Purpose : bundles the two client command/response channels and the RAM
//           port A connection of mem_port_arbiter.
// Signals :
//   req0/req1, we0/we1, addr0/addr1, wdata0/wdata1, lock0/lock1
//                      client commands (driven by the clients)
//   gnt0/gnt1          combinational grants (driven by the arbiter)
//   rvalid0/rvalid1    one-cycle read-data strobes (arbiter)
//   rdata0/rdata1      registered read data (arbiter)
//   mem_addr/mem_wdata/mem_we
//                      registered RAM port A command (arbiter)
//   mem_q              registered RAM port A read data (driven by the RAM)
// Modports:
//   slave  - the arbiter view
//   master - the environment view (clients plus RAM)
// ---------------------------------------------------------------------------
interface mem_port_arbiter_if #(
   parameter int unsigned DW = 16,
   parameter int unsigned AW = 10
);
   logic          req0;
   logic          req1;
   logic          we0;
   logic          we1;
   logic [AW-1:0] addr0;
   logic [AW-1:0] addr1;
   logic [DW-1:0] wdata0;
   logic [DW-1:0] wdata1;
   logic          lock0;
   logic          lock1;
   logic          gnt0;
   logic          gnt1;
   logic          rvalid0;
   logic          rvalid1;
   logic [DW-1:0] rdata0;
   logic [DW-1:0] rdata1;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic          mem_we;
   logic [DW-1:0] mem_q;

   modport slave (
      input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, lock0, lock1,
      input  mem_q,
      output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
      output mem_addr, mem_wdata, mem_we
   );

   modport master (
      output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, lock0, lock1,
      output mem_q,
      input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
      input  mem_addr, mem_wdata, mem_we
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
// Purpose : round-robin arbiter sharing port A of a single-clock RAM between
//           two clients. Commands move over a req/gnt handshake, the RAM port
//           is driven from registers, and read data returns to the issuing
//           client three cycles after its grant cycle. A client may lock the
//           port for short atomic sequences; the lock is bounded to MAX_LOCK
//           consecutive grants while the other client is waiting.
// Ports   :
//   clk    - clock, all state on the rising edge
//   rst_n  - asynchronous active-low reset
//   bus    - mem_port_arbiter_if.slave: client commands, grants, read
//            returns and the RAM port A command / read data
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
   parameter int unsigned DW       = 16,
   parameter int unsigned AW       = 10,
   parameter int unsigned MAX_LOCK = 4
) (
   input logic                clk,
   input logic                rst_n,
   mem_port_arbiter_if.slave  bus
);

   localparam int unsigned   CW         = 4;
   localparam logic [CW-1:0] LOCK_LIMIT = CW'(MAX_LOCK);
   localparam logic [CW-1:0] CNT_ONE    = CW'(1);
   localparam logic [CW-1:0] CNT_SAT    = {CW{1'b1}};

   // Arbitration state
   logic          last_q,     last_d;
   logic          own_lock_q, own_lock_d;
   logic [CW-1:0] lock_cnt_q, lock_cnt_d;

   // Command stage (RAM port A registers)
   logic [AW-1:0] mem_addr_q,  mem_addr_d;
   logic [DW-1:0] mem_wdata_q, mem_wdata_d;
   logic          mem_we_q,    mem_we_d;
   logic          s1_rd_q,     s1_rd_d;
   logic          s1_owner_q,  s1_owner_d;

   // Read-return pipeline
   logic          s2_rd_q,     s2_rd_d;
   logic          s2_owner_q,  s2_owner_d;
   logic          rvalid0_q,   rvalid0_d;
   logic          rvalid1_q,   rvalid1_d;
   logic [DW-1:0] rdata0_q,    rdata0_d;
   logic [DW-1:0] rdata1_q,    rdata1_d;

   // Grant decision
   logic          req_last_c;
   logic          req_other_c;
   logic          held_c;
   logic          expired_c;
   logic          xfer_c;
   logic          win_c;
   logic          win_lock_c;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_q      <= 1'b1;
         own_lock_q  <= 1'b0;
         lock_cnt_q  <= '0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         mem_we_q    <= 1'b0;
         s1_rd_q     <= 1'b0;
         s1_owner_q  <= 1'b0;
         s2_rd_q     <= 1'b0;
         s2_owner_q  <= 1'b0;
         rvalid0_q   <= 1'b0;
         rvalid1_q   <= 1'b0;
         rdata0_q    <= '0;
         rdata1_q    <= '0;
      end else begin
         last_q      <= last_d;
         own_lock_q  <= own_lock_d;
         lock_cnt_q  <= lock_cnt_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         mem_we_q    <= mem_we_d;
         s1_rd_q     <= s1_rd_d;
         s1_owner_q  <= s1_owner_d;
         s2_rd_q     <= s2_rd_d;
         s2_owner_q  <= s2_owner_d;
         rvalid0_q   <= rvalid0_d;
         rvalid1_q   <= rvalid1_d;
         rdata0_q    <= rdata0_d;
         rdata1_q    <= rdata1_d;
      end
   end

   // Grant: depends only on requests, lock inputs and registered state
   always_comb begin
      req_last_c  = 1'b0;
      req_other_c = 1'b0;
      held_c      = 1'b0;
      expired_c   = 1'b0;
      xfer_c      = 1'b0;
      win_c       = 1'b0;
      win_lock_c  = 1'b0;
      bus.gnt0    = 1'b0;
      bus.gnt1    = 1'b0;

      req_last_c  = last_q ? bus.req1 : bus.req0;
      req_other_c = last_q ? bus.req0 : bus.req1;
      // Ownership survives only while the locking client keeps requesting
      held_c      = own_lock_q & req_last_c;
      // Compare with >= so a count that grew while uncontended still expires
      expired_c   = (lock_cnt_q >= LOCK_LIMIT);
      xfer_c      = bus.req0 | bus.req1;

      if (held_c) begin
         win_c = (expired_c && req_other_c) ? ~last_q : last_q;
      end else if (bus.req0 && bus.req1) begin
         win_c = ~last_q;
      end else begin
         win_c = bus.req1;
      end

      win_lock_c = win_c ? bus.lock1 : bus.lock0;
      bus.gnt0   = xfer_c & ~win_c;
      bus.gnt1   = xfer_c &  win_c;
   end

   // Next state: arbitration bookkeeping, command stage, read return
   always_comb begin
      last_d      = last_q;
      own_lock_d  = own_lock_q;
      lock_cnt_d  = lock_cnt_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      mem_we_d    = 1'b0;
      s1_rd_d     = 1'b0;
      s1_owner_d  = s1_owner_q;
      s2_rd_d     = s1_rd_q;
      s2_owner_d  = s1_owner_q;
      rvalid0_d   = 1'b0;
      rvalid1_d   = 1'b0;
      rdata0_d    = rdata0_q;
      rdata1_d    = rdata1_q;

      if (xfer_c) begin
         last_d     = win_c;
         own_lock_d = win_lock_c;
         // Count consecutive locked grants; a new owner starts at one
         if (!win_lock_c) begin
            lock_cnt_d = '0;
         end else if (held_c && (win_c == last_q)) begin
            lock_cnt_d = (lock_cnt_q == CNT_SAT) ? lock_cnt_q : lock_cnt_q + CNT_ONE;
         end else begin
            lock_cnt_d = CNT_ONE;
         end

         mem_addr_d  = win_c ? bus.addr1  : bus.addr0;
         mem_wdata_d = win_c ? bus.wdata1 : bus.wdata0;
         mem_we_d    = win_c ? bus.we1    : bus.we0;
         s1_rd_d     = ~mem_we_d;
         s1_owner_d  = win_c;
      end else begin
         own_lock_d = 1'b0;
         lock_cnt_d = '0;
      end

      // RAM output is valid while stage 2 is occupied; capture it for the owner
      if (s2_rd_q) begin
         if (s2_owner_q) begin
            rvalid1_d = 1'b1;
            rdata1_d  = bus.mem_q;
         end else begin
            rvalid0_d = 1'b1;
            rdata0_d  = bus.mem_q;
         end
      end
   end

   // Registered outputs
   always_comb begin
      bus.mem_addr  = mem_addr_q;
      bus.mem_wdata = mem_wdata_q;
      bus.mem_we    = mem_we_q;
      bus.rvalid0   = rvalid0_q;
      bus.rvalid1   = rvalid1_q;
      bus.rdata0    = rdata0_q;
      bus.rdata1    = rdata1_q;
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
// Purpose : self-checking bench for mem_port_arbiter with a behavioural RAM
//           and a transaction-level reference model of grants and returns.
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;

   localparam int unsigned DW       = 16;
   localparam int unsigned AW       = 10;
   localparam int unsigned MAX_LOCK = 4;
   localparam int unsigned DEPTH    = 1024;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   mem_port_arbiter_if #(.DW(DW), .AW(AW)) bus ();

   mem_port_arbiter #(.DW(DW), .AW(AW), .MAX_LOCK(MAX_LOCK)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int total = 0;
   int bad   = 0;

   // Behavioural RAM port A: registered read, read-first
   logic [DW-1:0] ram [DEPTH];
   always @(posedge clk) begin
      if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
      bus.mem_q <= ram[bus.mem_addr];
   end

   // Reference model
   typedef struct {
      int            due;
      int            who;
      logic [DW-1:0] data;
      bit            known;
   } ret_t;

   int            m_last    = 1;
   bit            m_lockown = 1'b0;
   int            m_streak  = 0;
   logic [AW-1:0] m_addr    = '0;
   logic [DW-1:0] m_wdata   = '0;
   bit            m_we      = 1'b0;
   int            ecnt      = 0;
   logic [DW-1:0] shadow [DEPTH];
   bit            known  [DEPTH];
   ret_t          pend [$];
   logic [DW-1:0] e_rdata  [2];
   bit            e_rknown [2];

   // Which client should win now: -1 none, else 0/1
   function automatic int pick(input logic r0, input logic r1);
      if (!r0 && !r1) return -1;
      if (r0 != r1)   return r0 ? 0 : 1;
      if (m_lockown)  return (m_streak >= int'(MAX_LOCK)) ? 1 - m_last : m_last;
      return 1 - m_last;
   endfunction

   task automatic model_reset();
      m_last    = 1;
      m_lockown = 1'b0;
      m_streak  = 0;
      m_addr    = '0;
      m_wdata   = '0;
      m_we      = 1'b0;
      pend.delete();
      for (int k = 0; k < 2; k++) begin
         e_rdata[k]  = '0;
         e_rknown[k] = 1'b1;
      end
   endtask

   task automatic model_edge();
      int   w;
      bit   lk;
      ret_t r;
      ecnt++;
      w = pick(bus.req0, bus.req1);
      if (w < 0) begin
         m_we      = 1'b0;
         m_lockown = 1'b0;
         m_streak  = 0;
      end else begin
         lk = (w == 0) ? bus.lock0 : bus.lock1;
         if (!lk)                              m_streak = 0;
         else if (m_lockown && (w == m_last))  m_streak = (m_streak < 15) ? m_streak + 1 : 15;
         else                                  m_streak = 1;
         m_lockown = lk;
         m_last    = w;
         m_addr    = (w == 0) ? bus.addr0  : bus.addr1;
         m_wdata   = (w == 0) ? bus.wdata0 : bus.wdata1;
         m_we      = (w == 0) ? bus.we0    : bus.we1;
         if (m_we) begin
            shadow[m_addr] = m_wdata;
            known[m_addr]  = 1'b1;
         end else begin
            r.due   = ecnt + 2;
            r.who   = w;
            r.data  = shadow[m_addr];
            r.known = known[m_addr];
            pend.push_back(r);
         end
      end
   endtask

   // Compare registered outputs against the model every cycle
   task automatic monitor_check();
      bit   ev0, ev1;
      ret_t r;
      ev0 = 1'b0;
      ev1 = 1'b0;
      while (pend.size() != 0 && pend[0].due <= ecnt) begin
         r = pend.pop_front();
         if (r.who == 0) ev0 = 1'b1; else ev1 = 1'b1;
         e_rdata[r.who]  = r.data;
         e_rknown[r.who] = r.known;
      end
      total++;
      if (bus.rvalid0 !== ev0) begin
         bad++;
         $display("FAIL mon_rvalid0 t=%0t got=%0b exp=%0b", $time, bus.rvalid0, ev0);
      end
      total++;
      if (bus.rvalid1 !== ev1) begin
         bad++;
         $display("FAIL mon_rvalid1 t=%0t got=%0b exp=%0b", $time, bus.rvalid1, ev1);
      end
      if (e_rknown[0]) begin
         total++;
         if (bus.rdata0 !== e_rdata[0]) begin
            bad++;
            $display("FAIL mon_rdata0 t=%0t got=%h exp=%h", $time, bus.rdata0, e_rdata[0]);
         end
      end
      if (e_rknown[1]) begin
         total++;
         if (bus.rdata1 !== e_rdata[1]) begin
            bad++;
            $display("FAIL mon_rdata1 t=%0t got=%h exp=%h", $time, bus.rdata1, e_rdata[1]);
         end
      end
      total++;
      if (bus.mem_we !== m_we) begin
         bad++;
         $display("FAIL mon_mem_we t=%0t got=%0b exp=%0b", $time, bus.mem_we, m_we);
      end
      total++;
      if (bus.mem_addr !== m_addr) begin
         bad++;
         $display("FAIL mon_mem_addr t=%0t got=%h exp=%h", $time, bus.mem_addr, m_addr);
      end
      total++;
      if (bus.mem_wdata !== m_wdata) begin
         bad++;
         $display("FAIL mon_mem_wdata t=%0t got=%h exp=%h", $time, bus.mem_wdata, m_wdata);
      end
   endtask

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) model_reset();
      else        model_edge();
   end

   always @(negedge clk) monitor_check();

   task automatic drive(input logic r0, input logic w0, input logic [AW-1:0] a0,
                        input logic [DW-1:0] d0, input logic l0,
                        input logic r1, input logic w1, input logic [AW-1:0] a1,
                        input logic [DW-1:0] d1, input logic l1);
      bus.req0 = r0; bus.we0 = w0; bus.addr0 = a0; bus.wdata0 = d0; bus.lock0 = l0;
      bus.req1 = r1; bus.we1 = w1; bus.addr1 = a1; bus.wdata1 = d1; bus.lock1 = l1;
   endtask

   task automatic drive_idle();
      drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
   endtask

   task automatic test_reset();
      drive_idle();
      @(negedge clk);
      #1;
      total++;
      if ({bus.gnt0, bus.gnt1, bus.mem_we, bus.rvalid0, bus.rvalid1} !== 5'b0) begin
         bad++;
         $display("FAIL reset_ctrl got=%b exp=00000",
                  {bus.gnt0, bus.gnt1, bus.mem_we, bus.rvalid0, bus.rvalid1});
      end
      total++;
      if ({bus.mem_addr, bus.mem_wdata, bus.rdata0, bus.rdata1} !== '0) begin
         bad++;
         $display("FAIL reset_data addr=%h wdata=%h rdata0=%h rdata1=%h exp=0",
                  bus.mem_addr, bus.mem_wdata, bus.rdata0, bus.rdata1);
      end
      @(negedge clk);
      #2 rst_n = 1'b1;
   endtask

   // Write 30, read, write 400, read, all on client 0
   task automatic test_wr_rd_client0();
      logic          op_we [4];
      logic [DW-1:0] op_d  [4];
      logic          exp_we;
      op_we[0] = 1'b1; op_d[0] = DW'(30);
      op_we[1] = 1'b0; op_d[1] = '0;
      op_we[2] = 1'b1; op_d[2] = DW'(400);
      op_we[3] = 1'b0; op_d[3] = '0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (i >= 1) begin
            exp_we = (i <= 4) ? op_we[i-1] : 1'b0;
            total++;
            if (bus.mem_we !== exp_we) begin
               bad++;
               $display("FAIL wr_rd_mem_we i=%0d got=%0b exp=%0b", i, bus.mem_we, exp_we);
            end
         end
         total++;
         if (bus.rvalid0 !== 1'((i == 4) || (i == 6))) begin
            bad++;
            $display("FAIL wr_rd_rvalid0 i=%0d got=%0b", i, bus.rvalid0);
         end
         total++;
         if (bus.rvalid1 !== 1'b0) begin
            bad++;
            $display("FAIL wr_rd_rvalid1 i=%0d got=%0b exp=0", i, bus.rvalid1);
         end
         if (i == 4 || i == 6) begin
            total++;
            if (bus.rdata0 !== ((i == 4) ? DW'(30) : DW'(400))) begin
               bad++;
               $display("FAIL wr_rd_rdata0 i=%0d got=%0d exp=%0d", i, bus.rdata0,
                        (i == 4) ? 30 : 400);
            end
         end
         if (i < 4) drive(1'b1, op_we[i], '0, op_d[i], 1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
         else       drive_idle();
         #1;
         if (i < 4) begin
            total++;
            if ({bus.gnt0, bus.gnt1} !== 2'b10) begin
               bad++;
               $display("FAIL wr_rd_gnt i=%0d got=%b exp=10", i, {bus.gnt0, bus.gnt1});
            end
         end
      end
   endtask

   // Both clients read continuously: grants and returns alternate from client 0
   task automatic test_contention();
      bit exp0;
      @(negedge clk);
      drive(1'b1, 1'b1, AW'(5), DW'(16'h5A5A), 1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
      @(negedge clk);
      drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b1, 1'b1, AW'(9), DW'(16'hC3C3), 1'b0);
      @(negedge clk);
      drive_idle();
      @(negedge clk);
      #2 rst_n = 1'b0;
      @(negedge clk);
      #2 rst_n = 1'b1;
      for (int i = 0; i < 9; i++) begin
         @(negedge clk);
         if (i >= 3) begin
            exp0 = ((i - 3) % 2) == 0;
            total++;
            if ({bus.rvalid0, bus.rvalid1} !== {exp0, ~exp0}) begin
               bad++;
               $display("FAIL cont_rvalid i=%0d got=%b exp=%b", i,
                        {bus.rvalid0, bus.rvalid1}, {exp0, ~exp0});
            end
            total++;
            if (exp0 ? (bus.rdata0 !== 16'h5A5A) : (bus.rdata1 !== 16'hC3C3)) begin
               bad++;
               $display("FAIL cont_rdata i=%0d got0=%h got1=%h", i, bus.rdata0, bus.rdata1);
            end
         end
         if (i < 6) drive(1'b1, 1'b0, AW'(5), '0, 1'b0, 1'b1, 1'b0, AW'(9), '0, 1'b0);
         else       drive_idle();
         #1;
         if (i < 6) begin
            total++;
            if ({bus.gnt0, bus.gnt1} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin
               bad++;
               $display("FAIL cont_gnt i=%0d got=%b", i, {bus.gnt0, bus.gnt1});
            end
         end
      end
   endtask

   // Client 1 keeps the port for three grants, then client 0 gets it
   task automatic test_lock_within();
      logic [1:0] exp_g;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (i == 0) drive(1'b1, 1'b0, AW'(5), '0, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
         else        drive(1'b1, 1'b0, AW'(5), '0, 1'b0, 1'b1, 1'b0, AW'(9), '0, 1'(i < 3));
         #1;
         exp_g = (i >= 1 && i <= 3) ? 2'b01 : 2'b10;
         total++;
         if ({bus.gnt0, bus.gnt1} !== exp_g) begin
            bad++;
            $display("FAIL lock_gnt i=%0d got=%b exp=%b", i, {bus.gnt0, bus.gnt1}, exp_g);
         end
      end
      @(negedge clk);
      drive_idle();
   endtask

   // A lock held forever yields to the waiting client after MAX_LOCK grants
   task automatic test_lock_timeout();
      logic [1:0] exp_g;
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         drive(1'b1, 1'b1, AW'(16), DW'(i), 1'b0, 1'b1, 1'b1, AW'(17), DW'(100 + i), 1'b1);
         #1;
         exp_g = ((i % 5) < 4) ? 2'b01 : 2'b10;
         total++;
         if ({bus.gnt0, bus.gnt1} !== exp_g) begin
            bad++;
            $display("FAIL timeout_gnt i=%0d got=%b exp=%b", i, {bus.gnt0, bus.gnt1}, exp_g);
         end
      end
      @(negedge clk);
      drive_idle();
   endtask

   // Reset during an in-flight read discards it
   task automatic test_reset_mid_read();
      int rv_cnt;
      @(negedge clk);
      drive(1'b1, 1'b0, AW'(5), '0, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
      #1;
      total++;
      if (bus.gnt0 !== 1'b1) begin
         bad++;
         $display("FAIL rmr_gnt got=%0b exp=1", bus.gnt0);
      end
      @(negedge clk);
      drive_idle();
      #2 rst_n = 1'b0;
      for (int i = 0; i < 2; i++) begin
         #1;
         total++;
         if ({bus.gnt0, bus.gnt1, bus.mem_we, bus.rvalid0, bus.rvalid1, bus.mem_addr,
              bus.mem_wdata, bus.rdata0, bus.rdata1} !== '0) begin
            bad++;
            $display("FAIL rmr_outputs i=%0d we=%0b rv=%b addr=%h rd0=%h rd1=%h exp=0", i,
                     bus.mem_we, {bus.rvalid0, bus.rvalid1}, bus.mem_addr, bus.rdata0,
                     bus.rdata1);
         end
         @(negedge clk);
      end
      #2 rst_n = 1'b1;
      drive(1'b1, 1'b1, AW'(20), DW'(16'h1111), 1'b0, 1'b1, 1'b1, AW'(21), DW'(16'h2222), 1'b0);
      #1;
      total++;
      if ({bus.gnt0, bus.gnt1} !== 2'b10) begin
         bad++;
         $display("FAIL rmr_tie got=%b exp=10", {bus.gnt0, bus.gnt1});
      end
      rv_cnt = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         drive_idle();
         if (bus.rvalid0 || bus.rvalid1) rv_cnt++;
      end
      total++;
      if (rv_cnt !== 0) begin
         bad++;
         $display("FAIL rmr_strobes got=%0d exp=0", rv_cnt);
      end
   endtask

   // No requests: no grants, no writes, address held
   task automatic test_idle();
      @(negedge clk);
      drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b1, 1'b1, AW'(10'h155), DW'(16'hBEEF), 1'b0);
      @(negedge clk);
      drive_idle();
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         #1;
         total++;
         if ({bus.gnt0, bus.gnt1, bus.mem_we} !== 3'b000) begin
            bad++;
            $display("FAIL idle_ctrl i=%0d got=%b exp=000", i, {bus.gnt0, bus.gnt1, bus.mem_we});
         end
         total++;
         if (bus.mem_addr !== AW'(10'h155)) begin
            bad++;
            $display("FAIL idle_addr i=%0d got=%h exp=155", i, bus.mem_addr);
         end
      end
   endtask

   // Random traffic against the model
   task automatic test_random();
      for (int i = 0; i < 300; i++) begin
         int   exp_w;
         logic r0, r1;
         @(negedge clk);
         r0 = 1'($urandom_range(0, 9) < 7);
         r1 = 1'($urandom_range(0, 9) < 7);
         drive(r0, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), DW'($urandom),
               1'($urandom_range(0, 9) < 4),
               r1, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), DW'($urandom),
               1'($urandom_range(0, 9) < 4));
         #1;
         exp_w = pick(r0, r1);
         total++;
         if ({bus.gnt0, bus.gnt1} !== {1'(exp_w == 0), 1'(exp_w == 1)}) begin
            bad++;
            $display("FAIL rand_gnt i=%0d got=%b exp_winner=%0d", i, {bus.gnt0, bus.gnt1}, exp_w);
         end
      end
      @(negedge clk);
      drive_idle();
      repeat (5) @(negedge clk);
   endtask

   initial begin
      drive_idle();
      test_reset();
      test_wr_rd_client0();
      test_contention();
      test_lock_within();
      test_lock_timeout();
      test_reset_mid_read();
      test_idle();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester round-robin arbiter that shares port A of the 1024 x 16 single-clock true dual-port RAM (`mem_lab`). It accepts read/write commands from two clients over a req/gnt handshake and drives the RAM port from registers. It returns read data to the issuing client with a fixed latency. An optional lock keeps ownership for short atomic sequences such as read-modify-write. Port B of the RAM is not touched by this block.

## Interface
- `DW`, 16: data width; matches RAM word.
- `AW`, 10: address width; matches RAM depth 1024.
- `MAX_LOCK`, 4: max consecutive locked grants while the other client is requesting; range 1..15.
- `clk`  in  1  single clock; all state on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `req0`/`req1`  in  1  command request, client 0/1.
- `we0`/`we1`  in  1  1 = write, 0 = read.
- `addr0`/`addr1`  in  AW  command address.
- `wdata0`/`wdata1`  in  DW  write data.
- `lock0`/`lock1`  in  1  request to retain ownership for the next command.
- `gnt0`/`gnt1`  out  1  combinational grant. A command transfers at a rising edge where `reqN & gntN`.
- `rvalid0`/`rvalid1`  out  1  one-cycle read-data strobe.
- `rdata0`/`rdata1`  out  DW  read data, registered.
- `mem_addr`  out  AW  to RAM `addr_a`.
- `mem_wdata`  out  DW  to RAM `data_a`.
- `mem_we`  out  1  to RAM `we_a`.
- `mem_q`  in  DW  from RAM `q_a`. RAM output is registered: valid the cycle after the RAM samples the address.

## Operation
- Grant logic:
  - At most one of `gnt0`/`gnt1` is high in any cycle.
  - No grant is given without the matching req.
- Round robin:
  - State `last` (1 bit) holds the last granted client; reset value is 1, so client 0 wins the first tie.
  - If both clients request, the client != `last` wins, except under lock.
  - If one client requests, it wins.
- Lock:
  - Ownership is held when the last transfer had `lockN=1` and `reqN` is still high.
  - A 4-bit `lock_cnt` counts consecutive locked grants to the same owner.
  - If `lock_cnt == MAX_LOCK` and the other client requests, the other client wins and `lock_cnt` clears.
  - `lock_cnt` clears on ownership change, on a transfer with lock=0, or on an idle cycle.
  - With no contention, lock has no effect.
- Command stage (registered):
  - On a transfer: `mem_addr`/`mem_wdata` take the winner's values, `mem_we` = winner's `we`, and the stage records owner and read flag.
  - With no transfer: `mem_we` = 0, and `mem_addr`/`mem_wdata` hold their previous values.
- Read-return pipeline:
  - Stage-2 holds (valid, owner) for the read the RAM is servicing.
  - Stage-3 registers `mem_q` into `rdataN` of the owner and pulses `rvalidN`.
  - The other client's `rdata` holds its value.
- Writes produce no response.
- Throughput: one command per cycle. Back-to-back reads from both clients are fully pipelined and return in issue order.
- Write-then-read to the same address in consecutive transfers returns the new data, because the RAM executes them on successive edges.
- Reset (any time, including mid-read):
  - Values: `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `rvalid*`=0, `rdata*`=0, `last`=1, `lock_cnt`=0.
  - All pipeline valids clear; in-flight reads are discarded and never strobe.

## Timing
- Cycle C: `req0`=1, `gnt0`=1. The transfer happens at edge E1 ending C.
- E1: RAM-port registers update; `mem_we` is high during C+1 for a write.
- E2: RAM samples; `mem_q` is valid during C+2.
- E3: `rdata0` is loaded; `rvalid0` is high during C+3 only.
- Read latency: the strobe arrives 3 cycles after the grant cycle.
- `gnt` depends only on current req/lock inputs and registered state; there is no path from `mem_q` to `gnt`.

## Test plan
- Write/read sequence on client 0:
  - Stimulus: write 30 @0, read @0, write 400 @0, read @0, back-to-back.
  - Response: `mem_we` sequence 1,0,1,0. `rvalid0` is high 3 cycles after each read grant, with `rdata0`=30 then 400. `rvalid1` never asserts.
- Contention:
  - Stimulus: `req0`=`req1`=1 for 6 cycles, reads of addresses 5 and 9.
  - Response: grants alternate 0,1,0,1,0,1 starting with 0. Returns alternate with the correct data, one per cycle.
- Lock within limit:
  - Stimulus: client 1 locked for 3 grants while `req0` is held.
  - Response: `gnt1` is high 3 consecutive cycles, then `gnt0`.
- Lock timeout with `MAX_LOCK`=4:
  - Stimulus: client 1 holds lock and req indefinitely while `req0` is held.
  - Response: 4 `gnt1` cycles, then 1 `gnt0`, repeating.
- Reset mid-read:
  - Stimulus: read issued, `rst_n` pulled low one cycle after the grant, then released.
  - Response: no `rvalid`; all outputs are 0 during reset; the first grant after reset goes to client 0 on a tie.
- Idle:
  - Stimulus: no requests.
  - Response: no grants, `mem_we`=0, `mem_addr` holds its last value.
